// File: rtl/atm_session_ctrl.sv
// ATM session controller: account database, PIN login with lockout,
// balance/withdraw/deposit/transfer ops, idle timeout, 1-cycle responses.
//
// Ports:
//   clk, reset (sync, active-high)
//   cfg_we/cfg_idx/cfg_pin/cfg_bal   provisioning (IDLE only)
//   card_valid/card_idx              card insert
//   pin_valid/pin                    PIN entry
//   op_valid/op_code/op_amount/op_dest, op_ready   operation request
//   exit                             end session
//   resp_valid/resp_err/resp_balance response pulse
//   session_active                   MENU, EXEC or RESP
module atm_session_ctrl #(
  parameter int NUM_ACCTS = 16,
  parameter int BAL_W     = 16,
  parameter int PIN_W     = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000,
  localparam int IDX_W    = $clog2(NUM_ACCTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [PIN_W-1:0] cfg_pin,
  input  logic [BAL_W-1:0] cfg_bal,
  input  logic             card_valid,
  input  logic [IDX_W-1:0] card_idx,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [BAL_W-1:0] op_amount,
  input  logic [IDX_W-1:0] op_dest,
  input  logic             exit,
  output logic             op_ready,
  output logic             resp_valid,
  output logic [2:0]       resp_err,
  output logic [BAL_W-1:0] resp_balance,
  output logic             session_active
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_ACCTS);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_PIN   = 3'd1;
  localparam logic [2:0] E_LOCK  = 3'd2;
  localparam logic [2:0] E_INSUF = 3'd3;
  localparam logic [2:0] E_OVF   = 3'd4;
  localparam logic [2:0] E_ACCT  = 3'd5;
  localparam logic [2:0] E_OP    = 3'd6;
  localparam logic [2:0] E_TMO   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_MENU, S_EXEC, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       opc_q, opc_d;
  logic [BAL_W-1:0] amt_q, amt_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             exit_q, exit_d;
  logic             rv_q, rv_d;
  logic [2:0]       re_q, re_d;
  logic [BAL_W-1:0] rb_q, rb_d;

  logic [BAL_W-1:0] bal_q [NUM_ACCTS];
  logic [PIN_W-1:0] pin_q [NUM_ACCTS];
  logic [TRY_W-1:0] try_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q;

  logic [BAL_W-1:0] cur_bal, dst_bal;
  logic [BAL_W:0]   sum_src, sum_dst;
  logic [TRY_W-1:0] try_inc;
  logic [TMR_W-1:0] tmr_inc;
  logic             card_bad, cfg_ok, dst_bad;

  logic             cfg_wr, src_we, dst_we, try_we, lock_set;
  logic [BAL_W-1:0] src_val, dst_val;
  logic [TRY_W-1:0] try_val;

  assign cur_bal  = bal_q[idx_q];
  assign dst_bal  = bal_q[dst_q];
  assign sum_src  = {1'b0, cur_bal} + {1'b0, amt_q};
  assign sum_dst  = {1'b0, dst_bal} + {1'b0, amt_q};
  assign try_inc  = try_q[idx_q] + 1'b1;
  assign tmr_inc  = tmr_q + 1'b1;
  assign card_bad = {1'b0, card_idx} >= NUM_L;
  assign cfg_ok   = {1'b0, cfg_idx} < NUM_L;
  assign dst_bad  = ({1'b0, dst_q} >= NUM_L) || (dst_q == idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opc_d    = opc_q;
    amt_d    = amt_q;
    dst_d    = dst_q;
    tmr_d    = tmr_q;
    exit_d   = exit_q;
    rv_d     = 1'b0;
    re_d     = re_q;
    rb_d     = rb_q;
    cfg_wr   = 1'b0;
    src_we   = 1'b0;
    src_val  = cur_bal;
    dst_we   = 1'b0;
    dst_val  = dst_bal;
    try_we   = 1'b0;
    try_val  = '0;
    lock_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d  = '0;
        exit_d = 1'b0;
        cfg_wr = cfg_we && cfg_ok;
        if (card_valid) begin
          if (card_bad) begin
            rv_d = 1'b1; re_d = E_ACCT; rb_d = '0;
          end else if (lock_q[card_idx]) begin
            rv_d = 1'b1; re_d = E_LOCK; rb_d = '0;
          end else begin
            idx_d   = card_idx;
            state_d = S_PIN;
          end
        end
      end
      S_PIN: begin
        if (exit) begin
          state_d = S_IDLE;
        end else if (pin_valid) begin
          tmr_d  = '0;
          try_we = 1'b1;
          if (pin == pin_q[idx_q]) begin
            try_val = '0;
            state_d = S_MENU;
            rv_d = 1'b1; re_d = E_OK; rb_d = cur_bal;
          end else if (try_inc >= TRY_W'(MAX_TRIES)) begin
            try_val  = try_inc;
            lock_set = 1'b1;
            state_d  = S_IDLE;
            rv_d = 1'b1; re_d = E_LOCK; rb_d = '0;
          end else begin
            try_val = try_inc;
            rv_d = 1'b1; re_d = E_PIN; rb_d = '0;
          end
        end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          rv_d = 1'b1; re_d = E_TMO; rb_d = '0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_MENU: begin
        if (exit) begin
          state_d = S_IDLE;
        end else if (op_valid) begin
          opc_d   = op_code;
          amt_d   = op_amount;
          dst_d   = op_dest;
          tmr_d   = '0;
          state_d = S_EXEC;
        end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          rv_d = 1'b1; re_d = E_TMO; rb_d = cur_bal;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_EXEC: begin
        exit_d  = exit_q | exit;
        state_d = S_RESP;
        rv_d    = 1'b1;
        re_d    = E_OK;
        rb_d    = cur_bal;
        case (opc_q)
          3'd0: re_d = E_OK;
          3'd1: begin
            if (amt_q <= cur_bal) begin
              src_we  = 1'b1;
              src_val = cur_bal - amt_q;
              rb_d    = src_val;
            end else begin
              re_d = E_INSUF;
            end
          end
          3'd2: begin
            if (!sum_src[BAL_W]) begin
              src_we  = 1'b1;
              src_val = sum_src[BAL_W-1:0];
              rb_d    = src_val;
            end else begin
              re_d = E_OVF;
            end
          end
          3'd3: begin
            if (dst_bad) begin
              re_d = E_ACCT;
            end else if (amt_q > cur_bal) begin
              re_d = E_INSUF;
            end else if (sum_dst[BAL_W]) begin
              re_d = E_OVF;
            end else begin
              src_we  = 1'b1;
              src_val = cur_bal - amt_q;
              dst_we  = 1'b1;
              dst_val = sum_dst[BAL_W-1:0];
              rb_d    = src_val;
            end
          end
          default: re_d = E_OP;
        endcase
      end
      S_RESP: begin
        tmr_d   = '0;
        state_d = (exit_q || exit) ? S_IDLE : S_MENU;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      opc_q   <= '0;
      amt_q   <= '0;
      dst_q   <= '0;
      tmr_q   <= '0;
      exit_q  <= 1'b0;
      rv_q    <= 1'b0;
      re_q    <= '0;
      rb_q    <= '0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i] <= '0;
        pin_q[i] <= '0;
        try_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opc_q   <= opc_d;
      amt_q   <= amt_d;
      dst_q   <= dst_d;
      tmr_q   <= tmr_d;
      exit_q  <= exit_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rb_q    <= rb_d;
      if (cfg_wr) begin
        pin_q[cfg_idx]  <= cfg_pin;
        bal_q[cfg_idx]  <= cfg_bal;
        try_q[cfg_idx]  <= '0;
        lock_q[cfg_idx] <= 1'b0;
      end
      if (src_we)   bal_q[idx_q]  <= src_val;
      if (dst_we)   bal_q[dst_q]  <= dst_val;
      if (try_we)   try_q[idx_q]  <= try_val;
      if (lock_set) lock_q[idx_q] <= 1'b1;
    end
  end

  assign op_ready       = (state_q == S_MENU);
  assign session_active = (state_q == S_MENU) ||
                          (state_q == S_EXEC) ||
                          (state_q == S_RESP);
  assign resp_valid     = rv_q;
  assign resp_err       = re_q;
  assign resp_balance   = rb_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: directed scenarios and
// random sessions against a behavioural account model.
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [3:0]  cfg_pin;
  logic [15:0] cfg_bal;
  logic        card_valid;
  logic [3:0]  card_idx;
  logic        pin_valid;
  logic [3:0]  pin;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] op_amount;
  logic [3:0]  op_dest;
  logic        exit;
  logic        op_ready;
  logic        resp_valid;
  logic [2:0]  resp_err;
  logic [15:0] resp_balance;
  logic        session_active;

  atm_session_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
    .card_valid(card_valid), .card_idx(card_idx),
    .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op_code(op_code),
    .op_amount(op_amount), .op_dest(op_dest),
    .exit(exit), .op_ready(op_ready),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_balance(resp_balance),
    .session_active(session_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] exp_q [$];

  int m_bal [16];
  int m_pin [16];
  int m_try [16];
  bit m_lock [16];
  int cur;
  bit in_menu;

  task automatic chk(string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_resp: got err=%0d bal=%0d want none",
                 resp_err, resp_balance);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({resp_err, resp_balance} !== e) begin
          n_bad++;
          $display("FAIL resp: got err=%0d bal=%0d want err=%0d bal=%0d",
                   resp_err, resp_balance, e[18:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(int err, int bal);
    exp_q.push_back({3'(err), 16'(bal)});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_bal[i] = 0; m_pin[i] = 0; m_try[i] = 0; m_lock[i] = 0;
    end
    in_menu = 0;
  endtask

  task automatic do_cfg(int i, int p, int b);
    cfg_we = 1; cfg_idx = 4'(i); cfg_pin = 4'(p); cfg_bal = 16'(b);
    m_pin[i] = p; m_bal[i] = b; m_try[i] = 0; m_lock[i] = 0;
    step();
    cfg_we = 0;
  endtask

  task automatic do_card(int i, output bit ok);
    card_valid = 1; card_idx = 4'(i);
    ok = !m_lock[i];
    if (ok) cur = i;
    else push(2, 0);
    step();
    card_valid = 0;
  endtask

  task automatic do_pin(int p);
    pin_valid = 1; pin = 4'(p);
    if (p == m_pin[cur]) begin
      m_try[cur] = 0;
      in_menu = 1;
      push(0, m_bal[cur]);
    end else begin
      m_try[cur]++;
      if (m_try[cur] >= 3) begin
        m_lock[cur] = 1;
        push(2, 0);
      end else begin
        push(1, 0);
      end
    end
    step();
    pin_valid = 0;
  endtask

  task automatic do_op(int code, int amt, int dst, bit ex);
    int e;
    int b;
    b = m_bal[cur];
    case (code)
      0: e = 0;
      1: if (amt <= b) begin m_bal[cur] = b - amt; e = 0; end
         else e = 3;
      2: if (b + amt <= 65535) begin m_bal[cur] = b + amt; e = 0; end
         else e = 4;
      3: if (dst == cur) e = 5;
         else if (amt > b) e = 3;
         else if (m_bal[dst] + amt > 65535) e = 4;
         else begin
           m_bal[cur] = b - amt;
           m_bal[dst] = m_bal[dst] + amt;
           e = 0;
         end
      default: e = 6;
    endcase
    push(e, m_bal[cur]);
    op_valid = 1; op_code = 3'(code);
    op_amount = 16'(amt); op_dest = 4'(dst);
    step();
    op_valid = 0;
    chk("resp_early", int'(resp_valid), 0);
    exit = ex;
    step();
    exit = 0;
    chk("resp_latency", int'(resp_valid), 1);
    step();
    if (ex) in_menu = 0;
  endtask

  task automatic do_exit();
    exit = 1;
    step();
    exit = 0;
    in_menu = 0;
  endtask

  task automatic login(int i);
    bit ok;
    do_card(i, ok);
    do_pin(m_pin[i]);
  endtask

  initial begin
    bit ok;
    reset = 1; cfg_we = 0; cfg_idx = 0; cfg_pin = 0; cfg_bal = 0;
    card_valid = 0; card_idx = 0; pin_valid = 0; pin = 0;
    op_valid = 0; op_code = 0; op_amount = 0; op_dest = 0; exit = 0;
    model_clear();
    cur = 0;
    repeat (3) step();
    chk("rst_op_ready", int'(op_ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_resp_bal", int'(resp_balance), 0);
    chk("rst_active", int'(session_active), 0);
    reset = 0;
    step();

    // V1
    do_cfg(2, 5, 500);
    do_card(2, ok);
    chk("pin_wait_inactive", int'(session_active), 0);
    do_pin(5);
    chk("menu_ready", int'(op_ready), 1);
    do_op(1, 120, 0, 0);
    // V2
    do_op(1, 381, 0, 0);
    do_op(0, 0, 0, 0);
    do_exit();
    // V3
    do_cfg(3, 9, 65500);
    login(2);
    do_op(3, 100, 3, 0);
    do_op(3, 100, 2, 0);
    do_op(0, 0, 0, 0);
    do_op(2, 65535, 0, 0);
    do_op(5, 1, 0, 0);
    do_exit();
    login(3);
    do_op(0, 0, 0, 0);
    do_op(3, 35, 2, 0);
    do_exit();
    // V4
    do_card(2, ok);
    do_pin(7);
    do_pin(7);
    do_pin(7);
    chk("locked_idle", int'(session_active), 0);
    do_card(2, ok);
    do_cfg(2, 5, 415);
    login(2);
    chk("relogin_active", int'(session_active), 1);
    // V5
    repeat (990) step();
    chk("pre_timeout_active", int'(session_active), 1);
    push(7, m_bal[2]);
    in_menu = 0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    chk("timeout_seen", exp_q.size(), 0);
    chk("timeout_ready", int'(op_ready), 0);
    chk("timeout_active", int'(session_active), 0);
    // V6
    login(2);
    op_valid = 1; op_code = 3'd1; op_amount = 16'd10; exit = 1;
    step();
    op_valid = 0; exit = 0; in_menu = 0;
    chk("exit_wins_idle", int'(session_active), 0);
    login(2);
    do_op(0, 0, 0, 1);
    chk("exit_exec_idle", int'(session_active), 0);
    login(2);
    op_valid = 1; op_code = 3'd2; op_amount = 16'd50;
    step();
    op_valid = 0; reset = 1;
    step();
    reset = 0;
    model_clear();
    chk("mid_reset_active", int'(session_active), 0);
    login(2);
    do_op(0, 0, 0, 0);
    do_exit();
    login(3);
    do_op(0, 0, 0, 0);
    do_exit();

    // random sessions
    for (int i = 0; i < 8; i++)
      do_cfg(i, $urandom_range(0, 15), $urandom_range(0, 65535));
    for (int s = 0; s < 40; s++) begin
      int c;
      c = $urandom_range(0, 9);
      if (m_lock[c] && $urandom_range(0, 1) == 1)
        do_cfg(c, $urandom_range(0, 15), $urandom_range(0, 65535));
      do_card(c, ok);
      if (!ok) continue;
      for (int t = 0; t < 4 && !in_menu && !m_lock[c]; t++) begin
        if ($urandom_range(0, 2) == 0)
          do_pin((m_pin[c] + $urandom_range(1, 15)) % 16);
        else
          do_pin(m_pin[c]);
      end
      if (!in_menu) continue;
      for (int k = 0; k < $urandom_range(2, 6); k++) begin
        int code, amt, d;
        code = $urandom_range(0, 7);
        if (code > 3 && $urandom_range(0, 2) != 0)
          code = $urandom_range(1, 3);
        d = $urandom_range(0, 15);
        case ($urandom_range(0, 3))
          0: amt = $urandom_range(0, 200);
          1: amt = $urandom_range(0, 65535);
          2: amt = (code == 2) ? 65535 - m_bal[c] : m_bal[c];
          default: amt = (code == 2) ? 65536 - m_bal[c]
                                     : m_bal[c] + 1;
        endcase
        if (amt > 65535) amt = 65535;
        do_op(code, amt, d, 0);
      end
      if ($urandom_range(0, 3) == 0) do_op(0, 0, 0, 1);
      else do_exit();
    end

    repeat (4) step();
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Parameters
REQ-001 NUM_ACCTS, 16, number of accounts; IDX_W = clog2(NUM_ACCTS).
REQ-002 BAL_W, 16, balance and amount width in bits (unsigned).
REQ-003 PIN_W, 4, PIN width in bits.
REQ-004 MAX_TRIES, 3, consecutive bad PINs before the account locks.
REQ-005 TIMEOUT, 1000, idle cycles allowed in PIN_WAIT or MENU before the session is dropped.

Interface
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 cfg_we  in  1  provisioning write of PIN and balance; honoured only in IDLE.
REQ-009 cfg_idx / cfg_pin / cfg_bal  in  IDX_W / PIN_W / BAL_W  provisioning index, PIN, balance.
REQ-010 card_valid / card_idx  in  1 / IDX_W  card inserted; account index.
REQ-011 pin_valid / pin  in  1 / PIN_W  PIN entry strobe and value.
REQ-012 op_valid / op_code / op_amount / op_dest  in  1 / 3 / BAL_W / IDX_W  operation request.
REQ-013 exit  in  1  end session.
REQ-014 op_ready  out  1  high only in MENU.
REQ-015 resp_valid / resp_err / resp_balance  out  1 / 3 / BAL_W  one-cycle response pulse, error code, caller balance.
REQ-016 session_active  out  1  high in MENU, EXEC and RESP.

Function
REQ-017 States are IDLE, PIN_WAIT, MENU, EXEC and RESP.
REQ-018 Error codes: 0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 OVERFLOW, 5 BAD_ACCT, 6 BAD_OP, 7 TIMEOUT.
REQ-019 IDLE + card_valid:
- card_idx >= NUM_ACCTS -> resp BAD_ACCT next cycle, stay IDLE.
- account locked -> resp LOCKED next cycle, stay IDLE.
- otherwise latch index, go to PIN_WAIT, no response.
REQ-020 PIN_WAIT + pin_valid:
- match -> clear that account's try counter, go to MENU, resp OK next cycle.
- mismatch -> increment try counter, resp BAD_PIN next cycle.
- counter reaching MAX_TRIES -> set lock bit, resp LOCKED, go to IDLE.
REQ-021 MENU + op_valid accepted at cycle N -> EXEC at N+1 (database updated) -> RESP at N+2 (resp_valid high one cycle) -> MENU at N+3.
REQ-022 Op 0 BALANCE: no update, OK.
REQ-023 Op 1 WITHDRAW:
- amount <= balance -> subtract, OK.
- otherwise no change, INSUFFICIENT.
REQ-024 Op 2 DEPOSIT:
- sum fits BAL_W (computed BAL_W+1 wide) -> add, OK.
- otherwise no change, OVERFLOW.
REQ-025 Op 3 TRANSFER:
- op_dest >= NUM_ACCTS, or op_dest equal to the caller -> BAD_ACCT.
- amount > caller balance -> INSUFFICIENT.
- destination sum overflows -> OVERFLOW.
- otherwise debit caller and credit destination in the same EXEC cycle, OK.
REQ-026 Op codes 4-7 -> BAD_OP, no update.
REQ-027 resp_balance = caller balance after EXEC on every response in a session. It is 0 for responses issued in IDLE.
REQ-028 Any failed operation leaves every balance unchanged.
REQ-029 exit in PIN_WAIT or MENU -> IDLE next cycle, no response.
REQ-030 exit in EXEC or RESP -> the operation completes and its response is issued, then IDLE instead of MENU.
REQ-031 exit and op_valid in the same MENU cycle -> exit wins; the operation is not executed.
REQ-032 Idle timer:
- counts cycles in PIN_WAIT or MENU with no pin_valid or op_valid, and reloads on either.
- reaching TIMEOUT -> resp TIMEOUT, go to IDLE.
REQ-033 cfg_we in IDLE writes PIN and balance, clears the lock bit and try counter; ignored in every other state.
REQ-034 Inputs not listed as valid for the current state are ignored.
REQ-035 Try counters persist across sessions until a correct PIN or cfg_we.

Reset
REQ-036 Reset applies the following state on the next rising edge:
- FSM in IDLE.
- All balances, PINs, lock bits, try counters and the timer at 0.
- op_ready, resp_valid, resp_err, resp_balance and session_active at 0.
REQ-037 Reset asserted mid-session or mid-EXEC discards the session; no partial update survives reset.

Verification
REQ-038 Bench shall cover these directed scenarios:
- V1 Provision idx 2: PIN 5, balance 500; card 2, PIN 5; withdraw 120 -> OK, resp_balance 380, resp_valid exactly 2 cycles after acceptance.
- V2 Idx 2 at 380; withdraw 381 -> INSUFFICIENT, balance stays 380.
- V3 Idx 2 at 380, idx 3 at 65500 (BAL_W=16); transfer 100 to 3 -> OVERFLOW, both unchanged; transfer 100 to 2 -> BAD_ACCT.
- V4 Three PINs of 7 on idx 2 -> BAD_PIN, BAD_PIN, LOCKED; reinsert card 2 -> LOCKED; cfg_we idx 2 -> login succeeds.
- V5 Login, no activity for 1000 cycles -> TIMEOUT response, state IDLE, op_ready 0.
- V6 exit and op_valid withdraw 10 in the same cycle -> IDLE, no response, balance unchanged; reset during EXEC -> all balances 0.
